mem_boot_loader: RTL and testbench

MEM_BOOT_LOADER -- requirements
Module: mem_boot_loader

---
 rtl/mem_boot_loader_pkg.sv | 37 +++
 rtl/mem_boot_loader_port_mux.sv | 50 +++++
 rtl/mem_boot_loader.sv | 150 +++++++++++++++
 tb/tb_mem_boot_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM states, Wishbone address map
// fields, CTRL register layout and the loader's latched SRAM request.
package mem_boot_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CSEL = 2'd1,
      ST_WAIT = 2'd2,
      ST_ACK  = 2'd3
   } state_e;

   // Offset of the CTRL register inside the 64 KiB slave region
   localparam logic [15:0] CTRL_OFS = 16'h0000;

   // Memory window: adr[15:14] == WIN_TAG, bank = adr[13:12], word = adr[11:2]
   localparam int          WIN_HI  = 15;
   localparam int          WIN_LO  = 14;
   localparam logic [1:0]  WIN_TAG = 2'b01;
   localparam int          BANK_HI = 13;
   localparam int          BANK_LO = 12;
   localparam int          WORD_HI = 11;
   localparam int          WORD_LO = 2;

   // CTRL register bit positions
   localparam int          CTRL_HOLD_BIT = 0;
   localparam int          CTRL_BUSY_BIT = 1;

   // SRAM request captured when a window access is accepted
   typedef struct packed {
      logic [1:0]  bank;
      logic [9:0]  word;
      logic        we;
      logic [1:0]  wmask;
      logic [15:0] wdata;
   } ldr_req_t;

endpackage

// File: rtl/mem_boot_loader_port_mux.sv
// mem_port_mux: owner arbitration of the shared SRAM port.
//   ldr_en_i    loader owns the port this cycle (FSM in CSEL)
//   ldr_req_i   latched loader request
//   cpu_pass_i  CPU owns the port (hold released, FSM idle)
//   cpu_*_i/o   CPU side, passed through combinationally
//   mem_*_o/i   SRAM side; all chip selects high when nobody owns the port
module mem_port_mux
   import mem_boot_loader_pkg::*;
(
   input  logic        ldr_en_i,
   input  ldr_req_t    ldr_req_i,
   input  logic        cpu_pass_i,
   input  logic [11:0] cpu_addr_i,
   input  logic [15:0] cpu_wdata_i,
   input  logic        cpu_en_i,
   input  logic        cpu_rw_i,
   output logic [15:0] cpu_rdata_o,
   output logic [9:0]  mem_addr_o,
   output logic [15:0] mem_wdata_o,
   input  logic [15:0] mem_rdata_i,
   output logic [3:0]  mem_csb_o,
   output logic        mem_web_o,
   output logic [1:0]  mem_wmask_o
);

   always_comb begin
      mem_csb_o   = 4'hF;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_web_o   = 1'b1;
      mem_wmask_o = 2'b00;
      if (ldr_en_i) begin
         mem_csb_o[ldr_req_i.bank] = 1'b0;
         mem_addr_o  = ldr_req_i.word;
         mem_web_o   = !ldr_req_i.we;
         mem_wmask_o = ldr_req_i.wmask;
         mem_wdata_o = ldr_req_i.wdata;
      end else if (cpu_pass_i) begin
         mem_csb_o[cpu_addr_i[11:10]] = !cpu_en_i;
         mem_addr_o  = cpu_addr_i[9:0];
         mem_web_o   = !cpu_rw_i;
         mem_wmask_o = 2'b11;
         mem_wdata_o = cpu_wdata_i;
      end
   end

   // The CPU never sees loader traffic while it is held
   assign cpu_rdata_o = cpu_pass_i ? mem_rdata_i : '0;

endmodule

// File: rtl/mem_boot_loader.sv
// mem_boot_loader: Wishbone slave that loads a 4-bank SRAM while the CPU is
// held in reset, then hands the SRAM port to the CPU.
//   clk, rst_n      clock, async active-low reset
//   wbs_*           Wishbone slave (CTRL register at offset 0, memory window
//                   at adr[15:14] == 01, other offsets ack with zero data)
//   cpu_*           CPU SRAM port, passed through when hold is released
//   mem_*           shared SRAM port (per-bank active-low chip selects)
module mem_boot_loader
   import mem_boot_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic [11:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   input  logic        cpu_en,
   input  logic        cpu_rw,
   output logic        cpu_rst,
   output logic [9:0]  mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic [3:0]  mem_csb,
   output logic        mem_web,
   output logic [1:0]  mem_wmask
);

   state_e   state_q, state_d;
   logic     hold_q, hold_d;
   logic     ack_q, ack_d;
   logic [31:0] dat_q, dat_d;
   logic [15:0] rbuf_q, rbuf_d;
   ldr_req_t req_q, req_d;

   logic hit, is_win, is_ctrl, idle, start_mem, start_quick;
   logic ldr_en, fsm_ack, busy;
   logic [31:0] ctrl_rd;
   logic unused_bits;

   // ---------------- Wishbone decode ----------------
   assign hit     = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:16] == BASE_ADR[31:16]);
   assign is_win  = (wbs_adr_i[WIN_HI:WIN_LO] == WIN_TAG);
   assign is_ctrl = (wbs_adr_i[15:0] == CTRL_OFS);
   assign idle    = (state_q == ST_IDLE);
   // ack_q blocks re-accepting the strobe still high on the edge its ack is seen
   assign start_mem   = hit && idle && !ack_q && is_win && hold_q;
   assign start_quick = hit && idle && !ack_q && !(is_win && hold_q);

   assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_adr_i[1:0]};

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_mem) state_d = ST_CSEL;
         // A dropped cyc abandons the transfer; a write already issued stands
         ST_CSEL: state_d = wbs_cyc_i ? ST_WAIT : ST_IDLE;
         ST_WAIT: state_d = wbs_cyc_i ? ST_ACK  : ST_IDLE;
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ldr_en  = (state_q == ST_CSEL);
      fsm_ack = (state_q == ST_ACK);
      busy    = (state_q != ST_IDLE);
   end

   // ---------------- Datapath registers ----------------
   always_comb begin
      ctrl_rd = '0;
      ctrl_rd[CTRL_HOLD_BIT] = hold_q;
      ctrl_rd[CTRL_BUSY_BIT] = busy;
   end

   always_comb begin
      ack_d  = start_quick;
      dat_d  = dat_q;
      hold_d = hold_q;
      req_d  = req_q;
      rbuf_d = rbuf_q;
      if (start_quick) begin
         dat_d = (is_ctrl && !wbs_we_i) ? ctrl_rd : '0;
         // Only taken in IDLE, so ownership never flips mid-transfer
         if (is_ctrl && wbs_we_i && wbs_sel_i[0]) hold_d = wbs_dat_i[CTRL_HOLD_BIT];
      end
      if (start_mem) begin
         req_d.bank  = wbs_adr_i[BANK_HI:BANK_LO];
         req_d.word  = wbs_adr_i[WORD_HI:WORD_LO];
         req_d.we    = wbs_we_i;
         req_d.wmask = wbs_sel_i[1:0];
         req_d.wdata = wbs_dat_i[15:0];
      end
      if (state_q == ST_WAIT && wbs_cyc_i) rbuf_d = mem_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= 1'b1;
         ack_q  <= 1'b0;
         dat_q  <= '0;
         req_q  <= '0;
         rbuf_q <= '0;
      end else begin
         hold_q <= hold_d;
         ack_q  <= ack_d;
         dat_q  <= dat_d;
         req_q  <= req_d;
         rbuf_q <= rbuf_d;
      end
   end

   assign wbs_ack_o = ack_q || fsm_ack;
   assign wbs_dat_o = fsm_ack ? {16'h0000, rbuf_q} : dat_q;
   assign cpu_rst   = hold_q;

   // ---------------- SRAM port arbiter ----------------
   mem_port_mux u_mux (
      .ldr_en_i    (ldr_en),
      .ldr_req_i   (req_q),
      .cpu_pass_i  (!hold_q && idle),
      .cpu_addr_i  (cpu_addr),
      .cpu_wdata_i (cpu_wdata),
      .cpu_en_i    (cpu_en),
      .cpu_rw_i    (cpu_rw),
      .cpu_rdata_o (cpu_rdata),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata),
      .mem_csb_o   (mem_csb),
      .mem_web_o   (mem_web),
      .mem_wmask_o (mem_wmask)
   );

endmodule

// File: tb/tb_mem_boot_loader.sv
module tb_mem_boot_loader;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [11:0] cpu_addr;
   logic [15:0] cpu_wdata, cpu_rdata;
   logic        cpu_en, cpu_rw, cpu_rst;
   logic [9:0]  mem_addr;
   logic [15:0] mem_wdata;
   bit   [15:0] mem_rdata;
   logic [3:0]  mem_csb;
   logic        mem_web;
   logic [1:0]  mem_wmask;

   always #5 clk = ~clk;

   mem_boot_loader #(.BASE_ADR(BASE)) dut (
      .clk(clk), .rst_n(rst_n),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_en(cpu_en), .cpu_rw(cpu_rw), .cpu_rst(cpu_rst),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_csb(mem_csb), .mem_web(mem_web), .mem_wmask(mem_wmask)
   );

   // Environment: 4 banks of synchronous SRAM with registered read data
   bit [15:0] sram [4][1024];
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (!mem_csb[b]) begin
            if (!mem_web) begin
               if (mem_wmask[0]) sram[b][mem_addr][7:0]  <= mem_wdata[7:0];
               if (mem_wmask[1]) sram[b][mem_addr][15:8] <= mem_wdata[15:8];
            end else begin
               mem_rdata <= sram[b][mem_addr];
            end
         end
      end
   end

   // Reference model: flat image of what the memory should hold
   bit [15:0] shadow [4096];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Never more than one chip select active
   always @(negedge clk) chk("csb_onehot", 32'($countones(~mem_csb) <= 1), 32'd1);

   function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] m);
      merge = o;
      if (m[0]) merge[7:0]  = n[7:0];
      if (m[1]) merge[15:8] = n[15:8];
   endfunction

   function automatic logic [31:0] win_adr(input int bank, input int word);
      return BASE | 32'h4000 | (32'(bank) << 12) | (32'(word) << 2);
   endfunction

   function automatic logic [3:0] cpu_csb(input int bank);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << bank);
   endfunction

   // SRAM port snapshot one and two cycles after the strobe is sampled
   logic [3:0]  s1_csb, s2_csb;
   logic [9:0]  s1_addr;
   logic        s1_web;
   logic [1:0]  s1_mask;
   logic [15:0] s1_wdata;

   // Single Wishbone transfer, started on a falling edge. lat = cycles from
   // strobe sample to ack, 0 if no ack within the budget.
   task automatic wb(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                     input logic [3:0] sel, output logic [31:0] rd, output int lat);
      wbs_adr_i = adr; wbs_dat_i = dat; wbs_we_i = we; wbs_sel_i = sel;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      lat = 0; rd = '0;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk); @(negedge clk);
         if (n == 1) begin
            s1_csb = mem_csb; s1_addr = mem_addr; s1_web = mem_web;
            s1_mask = mem_wmask; s1_wdata = mem_wdata;
         end
         if (n == 2) s2_csb = mem_csb;
         if (wbs_ack_o) begin lat = n; rd = wbs_dat_o; break; end
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      @(negedge clk);
      chk("ack_single_cycle", 32'(wbs_ack_o), 32'd0);
   endtask

   logic [31:0] rd;
   int lat, bank, word, idx, k, t;
   logic we, seen;
   logic [3:0] sel;
   logic [15:0] d16, off, hi;

   initial begin
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
      wbs_adr_i = 0; wbs_dat_i = 0;
      cpu_addr = 0; cpu_wdata = 0; cpu_en = 0; cpu_rw = 0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_csb", 32'(mem_csb), 32'hF);
      chk("rst_ack", 32'(wbs_ack_o), 32'd0);
      chk("rst_dat", wbs_dat_o, 32'd0);
      chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("rst_web", 32'(mem_web), 32'd1);
      chk("rst_wmask", 32'(mem_wmask), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      wb(BASE, 0, 0, 4'hF, rd, lat);
      chk("ctrl_rd", rd, 32'h0000_0001);
      chk("ctrl_lat", lat, 1);
      chk("ctrl_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("ctrl_csb", 32'(mem_csb), 32'hF);

      // Loader write and the single CSEL cycle it produces
      wb(32'h3000_6008, 32'h0000_BEEF, 1, 4'h3, rd, lat);
      chk("w_lat", lat, 3);
      chk("w_csb", 32'(s1_csb), 32'b1011);
      chk("w_addr", 32'(s1_addr), 32'd2);
      chk("w_web", 32'(s1_web), 32'd0);
      chk("w_mask", 32'(s1_mask), 32'd3);
      chk("w_wdata", 32'(s1_wdata), 32'hBEEF);
      chk("w_csb_released", 32'(s2_csb), 32'hF);
      shadow[2*1024 + 2] = 16'hBEEF;

      wb(32'h3000_6008, 0, 0, 4'hF, rd, lat);
      chk("r_lat", lat, 3);
      chk("r_data", rd, 32'h0000_BEEF);

      // Byte mask: only the low byte of the second write lands
      wb(32'h3000_600C, 32'h0000_CAFE, 1, 4'h3, rd, lat);
      wb(32'h3000_600C, 32'h0000_0012, 1, 4'h1, rd, lat);
      wb(32'h3000_600C, 0, 0, 4'hF, rd, lat);
      chk("mask_rd", rd, 32'h0000_CA12);
      shadow[2*1024 + 3] = 16'hCA12;

      // Randomised loader traffic while the CPU is held
      for (int i = 0; i < 60; i++) begin
         k = $urandom_range(0, 9);
         we = 1'($urandom_range(0, 1));
         if (k <= 6) begin
            bank = $urandom_range(0, 3); word = $urandom_range(0, 7);
            idx = bank*1024 + word;
            sel = 4'($urandom); d16 = 16'($urandom);
            wb(win_adr(bank, word), {16'($urandom), d16}, we, sel, rd, lat);
            chk("rnd_win_lat", lat, 3);
            if (we) shadow[idx] = merge(shadow[idx], d16, sel[1:0]);
            else    chk("rnd_win_rd", rd, {16'h0, shadow[idx]});
         end else if (k <= 8) begin
            off = 16'($urandom);
            t = $urandom_range(0, 2);
            off[15:14] = (t == 0) ? 2'b00 : (t == 1) ? 2'b10 : 2'b11;
            if (off == 16'h0000) off = 16'h0010;
            wb({BASE[31:16], off}, $urandom, we, 4'hF, rd, lat);
            chk("rnd_other_lat", lat, 1);
            chk("rnd_other_rd", rd, 32'd0);
         end else begin
            hi = 16'($urandom);
            if (hi == BASE[31:16]) hi = hi + 16'd1;
            wb({hi, 16'h4000}, $urandom, we, 4'hF, rd, lat);
            chk("rnd_mismatch_noack", lat, 0);
         end
      end

      // Abort after CSEL: no ack, but the write stands
      wbs_adr_i = win_adr(1, 5); wbs_dat_i = 32'h0000_5A5A; wbs_we_i = 1; wbs_sel_i = 4'h3;
      wbs_cyc_i = 1; wbs_stb_i = 1;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      seen = 1'b0;
      repeat (4) begin @(negedge clk); seen = seen | wbs_ack_o; end
      chk("abort_noack", 32'(seen), 32'd0);
      shadow[1*1024 + 5] = 16'h5A5A;
      wb(win_adr(1, 5), 0, 0, 4'hF, rd, lat);
      chk("abort_write_stands", rd, 32'h0000_5A5A);

      // Hand the port to the CPU
      wb(BASE, 32'd0, 1, 4'hF, rd, lat);
      chk("hold_clr_lat", lat, 1);
      chk("hold_clr_cpu_rst", 32'(cpu_rst), 32'd0);
      cpu_en = 1; cpu_rw = 0; cpu_addr = 12'h802;
      #1;
      chk("cpu_csb", 32'(mem_csb), 32'b1011);
      chk("cpu_addr", 32'(mem_addr), 32'd2);
      chk("cpu_web", 32'(mem_web), 32'd1);
      @(negedge clk);
      chk("cpu_rdata", 32'(cpu_rdata), 32'h0000_BEEF);

      for (int i = 0; i < 30; i++) begin
         bank = $urandom_range(0, 3); word = $urandom_range(0, 7);
         idx = bank*1024 + word;
         cpu_addr = 12'(idx); cpu_rw = 1'($urandom_range(0, 1));
         cpu_wdata = 16'($urandom); cpu_en = 1;
         #1;
         chk("rnd_cpu_csb", 32'(mem_csb), 32'(cpu_csb(bank)));
         chk("rnd_cpu_mask", 32'(mem_wmask), 32'd3);
         @(negedge clk);
         if (cpu_rw) shadow[idx] = cpu_wdata;
         else        chk("rnd_cpu_rdata", 32'(cpu_rdata), {16'h0, shadow[idx]});
      end

      // Window access while released: quick ack, zero data, no SRAM write
      cpu_en = 1; cpu_rw = 0; cpu_addr = 12'(3*1024 + 5);
      wb(32'h3000_4000, 0, 0, 4'hF, rd, lat);
      chk("rel_rd_lat", lat, 1);
      chk("rel_rd_data", rd, 32'd0);
      chk("rel_csb_cpu_only", 32'(s1_csb), 32'b0111);
      cpu_en = 0;
      wb(32'h3000_4000, 32'h0000_DEAD, 1, 4'hF, rd, lat);
      chk("rel_wr_lat", lat, 1);
      chk("rel_wr_csb", 32'(s1_csb), 32'hF);
      cpu_en = 1; cpu_rw = 0; cpu_addr = 12'h000;
      @(negedge clk);
      chk("rel_no_write", 32'(cpu_rdata), {16'h0, shadow[0]});

      // Reset asserts hold asynchronously
      #2 rst_n = 1'b0;
      #1 chk("async_hold", 32'(cpu_rst), 32'd1);
      chk("async_csb", 32'(mem_csb), 32'hF);
      @(negedge clk); rst_n = 1'b1; cpu_en = 0;
      @(negedge clk);

      // Hold back on: CPU reads forced to zero, CPU not on the port
      wb(BASE, 32'd0, 1, 4'hF, rd, lat);
      cpu_en = 1; cpu_rw = 0; cpu_addr = 12'h802;
      @(negedge clk);
      wb(BASE, 32'd1, 1, 4'hF, rd, lat);
      chk("hold_set_cpu_rst", 32'(cpu_rst), 32'd1);
      #1 chk("hold_set_csb", 32'(mem_csb), 32'hF);
      @(negedge clk);
      chk("hold_cpu_rdata_zero", 32'(cpu_rdata), 32'd0);
      cpu_en = 0;

      // Reset during WAIT drops the transfer
      wbs_adr_i = win_adr(2, 2); wbs_we_i = 0; wbs_sel_i = 4'hF;
      wbs_cyc_i = 1; wbs_stb_i = 1;
      @(posedge clk); @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("wait_rst_ack", 32'(wbs_ack_o), 32'd0);
      chk("wait_rst_csb", 32'(mem_csb), 32'hF);
      chk("wait_rst_cpu_rst", 32'(cpu_rst), 32'd1);
      seen = 1'b0;
      repeat (2) begin @(negedge clk); seen = seen | wbs_ack_o; end
      wbs_cyc_i = 0; wbs_stb_i = 0;
      rst_n = 1'b1;
      repeat (3) begin @(negedge clk); seen = seen | wbs_ack_o; end
      chk("wait_rst_noack", 32'(seen), 32'd0);
      wb(BASE, 0, 0, 4'hF, rd, lat);
      chk("post_rst_ctrl", rd, 32'h0000_0001);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
